// File: rtl/qsys_sdram_cpu_dct_packer_if.sv
// Symbol-in / word-out handshake bundle for the trace-symbol packer.
// The packer side uses the master modport; the symbol source and word sink use slave.
interface qsys_sdram_cpu_dct_packer_if;
  logic        sym_valid;
  logic [1:0]  sym_data;
  logic        sym_ready;
  logic        word_valid;
  logic        word_ready;
  logic [29:0] word_data;
  logic [3:0]  word_count;

  modport master (
    input  sym_valid,
    input  sym_data,
    output sym_ready,
    output word_valid,
    input  word_ready,
    output word_data,
    output word_count
  );

  modport slave (
    output sym_valid,
    output sym_data,
    input  sym_ready,
    input  word_valid,
    output word_ready,
    input  word_data,
    input  word_count
  );
endinterface

// File: rtl/qsys_sdram_cpu_dct_packer.sv
// Packs 2-bit trace symbols into 30-bit MSB-aligned words (15 symbols max) with flush and
// end-of-test draining; exposes the live packing buffer and the test-ended status.
module qsys_sdram_cpu_dct_packer (
  input  logic                                clk,
  input  logic                                reset_n,
  qsys_sdram_cpu_dct_packer_if.master         bus,
  input  logic                                flush,
  input  logic                                test_ending,
  output logic [29:0]                         dct_buffer,
  output logic [3:0]                          dct_count,
  output logic                                test_has_ended
);

  typedef enum logic [1:0] {StRun, StEnding, StEnded} state_e;

  state_e      state_q, state_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  count_q, count_d;
  logic        word_valid_q, word_valid_d;
  logic [29:0] word_data_q, word_data_d;
  logic [3:0]  word_count_q, word_count_d;
  logic        pending_q, pending_d;
  logic        issued_q, issued_d;
  logic        ended_q, ended_d;

  logic        slot_free, sym_ready, accept, ending_entry, flush_req;
  logic [29:0] shifted, packed_word;
  logic [3:0]  eff;
  logic [4:0]  shamt;

  always_comb begin
    slot_free    = !word_valid_q | bus.word_ready;
    // Once the final ENDING flush has gone out, no further symbols may enter.
    sym_ready    = reset_n & slot_free &
                   ((state_q == StRun) | ((state_q == StEnding) & !issued_q));
    accept       = bus.sym_valid & sym_ready;
    shifted      = {buf_q[27:0], bus.sym_data};
    packed_word  = accept ? shifted : buf_q;
    eff          = count_q + {3'b000, accept};
    shamt        = {4'd15 - eff, 1'b0};
    ending_entry = (state_q == StRun) & test_ending;
    flush_req    = flush | pending_q | ending_entry;
  end

  always_comb begin
    buf_d        = buf_q;
    count_d      = count_q;
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    word_count_d = word_count_q;
    pending_d    = pending_q;

    if (word_valid_q && bus.word_ready) word_valid_d = 1'b0;

    if (accept) begin
      buf_d   = shifted;
      count_d = count_q + 4'd1;
    end

    if (accept && count_q == 4'd14) begin
      // A full word also satisfies any flush requested in the same cycle.
      word_data_d  = shifted;
      word_count_d = 4'd15;
      word_valid_d = 1'b1;
      buf_d        = '0;
      count_d      = '0;
      pending_d    = 1'b0;
    end else if (flush_req) begin
      if (eff == 4'd0) begin
        pending_d = 1'b0;
      end else if (slot_free) begin
        word_data_d  = packed_word << shamt;
        word_count_d = eff;
        word_valid_d = 1'b1;
        buf_d        = '0;
        count_d      = '0;
        pending_d    = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (test_ending) begin
          if (eff == 4'd0 && !pending_q && slot_free) state_d = StEnded;
          else                                        state_d = StEnding;
        end
      end
      StEnding: begin
        if (count_q == 4'd0 && !pending_q && issued_q && slot_free) state_d = StEnded;
      end
      StEnded: state_d = StEnded;
      default: state_d = StRun;
    endcase
    issued_d = issued_q | ((ending_entry | (state_q == StEnding)) & !pending_d);
    ended_d  = ended_q | (state_d == StEnded);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StRun;
      buf_q        <= '0;
      count_q      <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_count_q <= '0;
      pending_q    <= 1'b0;
      issued_q     <= 1'b0;
      ended_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      count_q      <= count_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      word_count_q <= word_count_d;
      pending_q    <= pending_d;
      issued_q     <= issued_d;
      ended_q      <= ended_d;
    end
  end

  assign bus.sym_ready   = sym_ready;
  assign bus.word_valid  = word_valid_q;
  assign bus.word_data   = word_data_q;
  assign bus.word_count  = word_count_q;
  assign dct_buffer      = buf_q;
  assign dct_count       = count_q;
  assign test_has_ended  = ended_q;

endmodule

// File: tb/tb_qsys_sdram_cpu_dct_packer.sv
// Scoreboard bench for the trace-symbol packer: stimulus pushes expected words, a monitor
// pops and compares on every word handshake.
module tb_qsys_sdram_cpu_dct_packer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush, test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q[$];
  logic [1:0]  mq[$];
  logic [29:0] last_word;

  qsys_sdram_cpu_dct_packer_if bus ();

  qsys_sdram_cpu_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .flush          (flush),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [29:0] data, input logic [3:0] cnt);
    exp_q.push_back({cnt, data});
    last_word = data;
  endtask

  // Reference packer: symbol i of a word lands at bits [29-2i -: 2].
  task automatic model_emit();
    logic [29:0] w;
    w = '0;
    for (int i = 0; i < mq.size(); i++) w[29 - 2*i -: 2] = mq[i];
    push_exp(w, 4'(mq.size()));
    mq.delete();
  endtask

  task automatic model_add(input logic [1:0] s);
    mq.push_back(s);
    if (mq.size() == 15) model_emit();
  endtask

  task automatic model_flush();
    if (mq.size() > 0) model_emit();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] s, input bit use_model);
    bit acc_now;
    bit accepted;
    accepted = 0;
    bus.sym_valid = 1'b1;
    bus.sym_data  = s;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      acc_now = bus.sym_ready;
      tick();
      if (acc_now) accepted = 1;
    end
    bus.sym_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL sym_accept_timeout: got no accept, expected accept within 50 cycles");
    end else if (use_model) begin
      model_add(s);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && bus.word_valid && bus.word_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h/%0d, expected no word", bus.word_data,
                 bus.word_count);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("word_data", {2'b00, bus.word_data}, {2'b00, e[29:0]});
        check("word_count", {28'd0, bus.word_count}, {28'd0, e[33:30]});
      end
    end
  end

  initial begin
    reset_n        = 1'b0;
    flush          = 1'b0;
    test_ending    = 1'b0;
    bus.sym_valid  = 1'b0;
    bus.sym_data   = 2'd0;
    bus.word_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_sym_ready", {31'd0, bus.sym_ready}, 32'd0);
    check("rst_word_valid", {31'd0, bus.word_valid}, 32'd0);
    check("rst_dct_count", {28'd0, dct_count}, 32'd0);
    check("rst_dct_buffer", {2'b00, dct_buffer}, 32'd0);
    check("rst_has_ended", {31'd0, test_has_ended}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Full word of 0,1,2,3,...
    push_exp(30'h06C6C6C6, 4'd15);
    for (int i = 0; i < 15; i++) send_sym(2'(i % 4), 1'b0);
    check("full_word_valid", {31'd0, bus.word_valid}, 32'd1);
    check("full_dct_count", {28'd0, dct_count}, 32'd0);

    // Partial word 3,2,1 via flush.
    push_exp(30'h39000000, 4'd3);
    send_sym(2'd3, 1'b0);
    send_sym(2'd2, 1'b0);
    send_sym(2'd1, 1'b0);
    pulse_flush();
    check("flush_word_valid", {31'd0, bus.word_valid}, 32'd1);
    check("flush_dct_buffer", {2'b00, dct_buffer}, 32'd0);
    tick();

    // Backpressure: pending full word, then 20 more symbols.
    bus.word_ready = 1'b0;
    for (int i = 0; i < 15; i++) send_sym(2'((i * 3 + 1) % 4), 1'b1);
    bus.sym_valid = 1'b1;
    bus.sym_data  = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_sym_ready", {31'd0, bus.sym_ready}, 32'd0);
      check("stall_word_stable", {2'b00, bus.word_data}, {2'b00, last_word});
      tick();
    end
    bus.word_ready = 1'b1;
    for (int i = 0; i < 20; i++) send_sym(2'((i * 7 + 2) % 4), 1'b1);
    model_flush();
    pulse_flush();
    tick();
    tick();

    // Flush on an empty buffer does nothing.
    pulse_flush();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("empty_flush_no_word", {31'd0, bus.word_valid}, 32'd0);
      tick();
    end

    // Flush coinciding with the 5th symbol includes it.
    push_exp(30'h15600000, 4'd5);
    for (int i = 0; i < 4; i++) send_sym(2'd1, 1'b0);
    flush = 1'b1;
    send_sym(2'd2, 1'b0);
    flush = 1'b0;
    check("flush5_dct_count", {28'd0, dct_count}, 32'd0);
    check("flush5_word_count", {28'd0, bus.word_count}, 32'd5);
    tick();

    // End of test with five buffered symbols and a stalled sink.
    for (int i = 0; i < 5; i++) send_sym(2'd3, 1'b0);
    push_exp(30'h3FF00000, 4'd5);
    bus.word_ready = 1'b0;
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("end_word_valid", {31'd0, bus.word_valid}, 32'd1);
      check("end_not_ended", {31'd0, test_has_ended}, 32'd0);
      check("end_sym_ready", {31'd0, bus.sym_ready}, 32'd0);
      tick();
    end
    bus.word_ready = 1'b1;
    tick();
    check("end_has_ended", {31'd0, test_has_ended}, 32'd1);
    bus.sym_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ended_sym_ready", {31'd0, bus.sym_ready}, 32'd0);
      check("ended_still", {31'd0, test_has_ended}, 32'd1);
      tick();
    end
    bus.sym_valid = 1'b0;

    reset_n = 1'b0;
    tick();
    check("rst2_has_ended", {31'd0, test_has_ended}, 32'd0);
    check("rst2_word_valid", {31'd0, bus.word_valid}, 32'd0);
    check("rst2_word_data", {2'b00, bus.word_data}, 32'd0);
    check("rst2_word_count", {28'd0, bus.word_count}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Reset mid-word discards buffered symbols.
    send_sym(2'd2, 1'b0);
    send_sym(2'd2, 1'b0);
    reset_n = 1'b0;
    tick();
    check("rst3_dct_count", {28'd0, dct_count}, 32'd0);
    check("rst3_dct_buffer", {2'b00, dct_buffer}, 32'd0);
    reset_n = 1'b1;
    tick();
    push_exp(30'h39000000, 4'd3);
    send_sym(2'd3, 1'b0);
    send_sym(2'd2, 1'b0);
    send_sym(2'd1, 1'b0);
    pulse_flush();
    for (int i = 0; i < 4; i++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
